// File: rtl/bullet_hit_scanner_pkg.sv
// Shared definitions for the bullet hit scanner: colour codes, pos/size word
// field positions and the scan FSM encoding.
package bullet_hit_scanner_pkg;

    localparam logic [1:0] COLOR_WHITE = 2'd0;
    localparam logic [1:0] COLOR_GREEN = 2'd1;
    localparam logic [1:0] COLOR_BLUE  = 2'd2;

    // x/w live in the high byte of a pos/size word, y/h in the low byte
    localparam int HI_MSB = 15;
    localparam int HI_LSB = 8;
    localparam int LO_MSB = 7;
    localparam int LO_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_HIT     = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } scan_state_e;

endpackage

// File: rtl/bullet_hit_scanner_box_overlap.sv
// Combinational axis-aligned box overlap test in 9-bit unsigned arithmetic.
// Touching edges and zero-sized boxes never count as overlap.
module box_overlap
    import bullet_hit_scanner_pkg::*;
(
    input  logic [15:0] a_pos,
    input  logic [15:0] a_size,
    input  logic [15:0] b_pos,
    input  logic [15:0] b_size,
    output logic        hit
);

    logic [8:0] ax_s, ay_s, aw_s, ah_s;
    logic [8:0] bx_s, by_s, bw_s, bh_s;
    logic       nonzero_s;

    assign ax_s = {1'b0, a_pos[HI_MSB:HI_LSB]};
    assign ay_s = {1'b0, a_pos[LO_MSB:LO_LSB]};
    assign aw_s = {1'b0, a_size[HI_MSB:HI_LSB]};
    assign ah_s = {1'b0, a_size[LO_MSB:LO_LSB]};
    assign bx_s = {1'b0, b_pos[HI_MSB:HI_LSB]};
    assign by_s = {1'b0, b_pos[LO_MSB:LO_LSB]};
    assign bw_s = {1'b0, b_size[HI_MSB:HI_LSB]};
    assign bh_s = {1'b0, b_size[LO_MSB:LO_LSB]};

    // A zero-width or zero-height box could otherwise pass the strict compares
    assign nonzero_s = (aw_s != 9'd0) && (ah_s != 9'd0) && (bw_s != 9'd0) && (bh_s != 9'd0);

    assign hit = nonzero_s
               && (bx_s < ax_s + aw_s) && (ax_s < bx_s + bw_s)
               && (by_s < ay_s + ah_s) && (ay_s < by_s + bh_s);

endmodule

// File: rtl/bullet_hit_scanner.sv
// Walks the bullet table once per frame tick, pulses is_collide on overlap with
// the heart box and applies colour-dependent damage or heal to a saturating HP.
module bullet_hit_scanner
    import bullet_hit_scanner_pkg::*;
#(
    parameter int          NUM_BULLETS   = 3,
    parameter int          IDX_W         = 3,
    parameter logic [7:0]  MAX_HP        = 8'd20,
    parameter logic [7:0]  DMG           = 8'd4,
    parameter logic [7:0]  HEAL          = 8'd2,
    parameter logic [15:0] INVULN_CYCLES = 16'd50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_run,
    input  logic             scan_start,
    input  logic [15:0]      player_pos,
    input  logic [15:0]      player_size,
    input  logic             player_moving,
    output logic [IDX_W-1:0] bl_index,
    input  logic [15:0]      bl_pos,
    input  logic [15:0]      bl_size,
    input  logic [1:0]       bl_color,
    input  logic             bl_render,
    output logic             is_collide,
    output logic [7:0]       hp,
    output logic             is_dead,
    output logic             scan_busy,
    output logic             scan_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BULLETS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    scan_state_e      state_r, state_nxt;
    logic [IDX_W-1:0] idx_r, idx_nxt;
    logic [15:0]      held_pos_r, held_size_r;
    logic [1:0]       held_color_r;
    logic             held_render_r;
    logic [7:0]       hp_r, hp_nxt;
    logic [15:0]      invuln_r, invuln_nxt;
    logic             is_dead_r, is_collide_r, scan_busy_r, scan_done_r;
    logic             overlap_s, do_dmg_s, do_heal_s, in_hit_s, dmg_taken_s;
    logic [8:0]       heal_sum_s;

    box_overlap u_overlap (
        .a_pos  (player_pos),
        .a_size (player_size),
        .b_pos  (held_pos_r),
        .b_size (held_size_r),
        .hit    (overlap_s)
    );

    // Scan sequencing: next state and slot index
    always_comb begin
        state_nxt = state_r;
        idx_nxt   = idx_r;
        if (!is_run) begin
            state_nxt = ST_IDLE;
            idx_nxt   = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_start) begin
                        state_nxt = ST_FETCH;
                        idx_nxt   = IDX_ZERO;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH:   state_nxt = ST_COMPARE;
                ST_COMPARE: begin
                    if (held_render_r && overlap_s) begin
                        state_nxt = ST_HIT;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
                ST_HIT:     state_nxt = ST_NEXT;
                ST_NEXT: begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FETCH;
                        idx_nxt   = idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = IDX_ZERO;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = IDX_ZERO;
                end
            endcase
        end
    end

    // Colour decides whether the slot in HIT damages, heals or does nothing
    always_comb begin
        do_dmg_s  = 1'b0;
        do_heal_s = 1'b0;
        case (held_color_r)
            COLOR_WHITE: do_dmg_s  = 1'b1;
            COLOR_BLUE:  do_dmg_s  = player_moving;
            COLOR_GREEN: do_heal_s = ~is_dead_r;
            default: begin
                do_dmg_s  = 1'b0;
                do_heal_s = 1'b0;
            end
        endcase
    end

    assign in_hit_s    = (state_r == ST_HIT);
    assign dmg_taken_s = in_hit_s && do_dmg_s && (invuln_r == 16'd0);
    assign heal_sum_s  = {1'b0, hp_r} + {1'b0, HEAL};

    // Saturating HP update and invulnerability countdown
    always_comb begin
        hp_nxt     = hp_r;
        invuln_nxt = invuln_r;
        if (!is_run) begin
            hp_nxt     = MAX_HP;
            invuln_nxt = 16'd0;
        end else if (dmg_taken_s) begin
            hp_nxt     = (hp_r > DMG) ? (hp_r - DMG) : 8'd0;
            invuln_nxt = INVULN_CYCLES;
        end else begin
            if (in_hit_s && do_heal_s) begin
                hp_nxt = (heal_sum_s > {1'b0, MAX_HP}) ? MAX_HP : heal_sum_s[7:0];
            end else begin
                hp_nxt = hp_r;
            end
            if (invuln_r != 16'd0) begin
                invuln_nxt = invuln_r - 16'd1;
            end else begin
                invuln_nxt = invuln_r;
            end
        end
    end

    // State, HP and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            hp_r         <= MAX_HP;
            invuln_r     <= 16'd0;
            is_dead_r    <= 1'b0;
            is_collide_r <= 1'b0;
            scan_busy_r  <= 1'b0;
            scan_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            idx_r        <= idx_nxt;
            hp_r         <= hp_nxt;
            invuln_r     <= invuln_nxt;
            is_dead_r    <= (hp_nxt == 8'd0);
            is_collide_r <= (state_nxt == ST_HIT);
            scan_busy_r  <= (state_nxt != ST_IDLE);
            scan_done_r  <= (state_nxt == ST_DONE);
        end
    end

    // Capture the addressed slot at the end of FETCH (table read is combinational)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_pos_r    <= 16'd0;
            held_size_r   <= 16'd0;
            held_color_r  <= 2'd0;
            held_render_r <= 1'b0;
        end else if (state_r == ST_FETCH) begin
            held_pos_r    <= bl_pos;
            held_size_r   <= bl_size;
            held_color_r  <= bl_color;
            held_render_r <= bl_render;
        end
    end

    assign bl_index   = idx_r;
    assign is_collide = is_collide_r;
    assign hp         = hp_r;
    assign is_dead    = is_dead_r;
    assign scan_busy  = scan_busy_r;
    assign scan_done  = scan_done_r;

endmodule
